// File: rtl/instr_monitor.sv
// Retirement monitor: classifies retired instructions, keeps saturating event
// counters, detects halt and enforces a cycle budget. INSTR_MONITOR_PC_HIST_EN adds a PC history buffer.
module instr_monitor #(
    parameter int unsigned    XLEN       = 32,
    parameter int unsigned    CNT_W      = 32,
    parameter int unsigned    MAX_CYCLES = 200,
    parameter logic [XLEN-1:0] HALT_INSTR = '0,
    parameter int unsigned    HIST_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          instr_valid,
    input  logic [XLEN-1:0]               instr,
    input  logic [XLEN-1:0]               pc,
    input  logic                          mem_write,
    input  logic                          branch,
    input  logic                          clear,
    input  logic [2:0]                    rd_sel,
    output logic [CNT_W-1:0]              rd_data,
    output logic [CNT_W-1:0]              cycle_count,
    output logic [CNT_W-1:0]              instr_count,
    output logic                          halted,
    output logic                          timeout,
    output logic [XLEN-1:0]               halt_pc,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [XLEN-1:0]               hist_data
);

    localparam int unsigned N_EV = 8;

    typedef enum logic [1:0] {RUN, HALTED, TIMEOUT} state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  ev_cnt [N_EV];
    logic [N_EV-1:0]   ev_hit;
    logic [2:0]        cls;
    logic [CNT_W-1:0]  cyc_inc;
    logic              is_halt;
    logic              hit_budget;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Opcode class of the retiring instruction
    always_comb begin
        cls = 3'd5;
        case (instr[6:0])
            7'b0110011: cls = 3'd0;
            7'b0010011: cls = 3'd1;
            7'b0000011: cls = 3'd2;
            7'b0100011: cls = 3'd3;
            7'b1100011: cls = 3'd4;
            default:    cls = 3'd5;
        endcase
    end

    always_comb begin
        ev_hit      = '0;
        ev_hit[cls] = 1'b1;
        ev_hit[6]   = branch;
        ev_hit[7]   = mem_write;
    end

    assign cyc_inc    = sat_inc(cycle_count);
    assign is_halt    = instr_valid && (instr == HALT_INSTR);
    assign hit_budget = (cyc_inc == CNT_W'(MAX_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // Halt beats timeout when both land on the same cycle
    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (is_halt)         state_next = HALTED;
                    else if (hit_budget) state_next = TIMEOUT;
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            halted  <= (state_next == HALTED);
            timeout <= (state_next == TIMEOUT);
        end
    end

    // Counters only move in RUN; HALTED/TIMEOUT freeze everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
            instr_count <= '0;
            halt_pc     <= '0;
            for (int i = 0; i < N_EV; i++) ev_cnt[i] <= '0;
        end else if (clear) begin
            cycle_count <= '0;
            instr_count <= '0;
            halt_pc     <= '0;
            for (int i = 0; i < N_EV; i++) ev_cnt[i] <= '0;
        end else if (state == RUN) begin
            cycle_count <= cyc_inc;
            if (instr_valid) begin
                instr_count <= sat_inc(instr_count);
                for (int i = 0; i < N_EV; i++) begin
                    if (ev_hit[i]) ev_cnt[i] <= sat_inc(ev_cnt[i]);
                end
            end
            if (is_halt) halt_pc <= pc;
        end
    end

    assign rd_data = ev_cnt[rd_sel];

`ifdef INSTR_MONITOR_PC_HIST_EN
    localparam int unsigned HIST_W = $clog2(HIST_DEPTH);

    logic [XLEN-1:0]   hist_mem [HIST_DEPTH];
    logic [HIST_W-1:0] wptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
        end else if (clear) begin
            wptr <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
        end else if (state == RUN && instr_valid) begin
            hist_mem[wptr] <= pc;
            wptr           <= wptr + HIST_W'(1);
        end
    end

    // Pointer arithmetic wraps naturally because HIST_DEPTH is a power of 2
    assign hist_data = hist_mem[wptr - HIST_W'(1) - hist_idx];
`else
    logic unused_hist;
    assign unused_hist = ^hist_idx;
    assign hist_data   = '0;
`endif

endmodule
